// File: rtl/fxp2float_pipe.sv
// fxp2float_pipe: 3-stage streaming fixed-point (Q.FRAC_W) to IEEE-754 binary32 converter
// with round-to-nearest-even, valid/ready backpressure and a passthrough tag.
module fxp2float_pipe #(
    parameter int FXP_W  = 8,
    parameter int FRAC_W = 4,
    parameter int SIGNED = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FXP_W-1:0] in_fxp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_fp32,
    output logic [TAG_W-1:0] out_tag
);
    logic             en;
    logic             s1_v_q, s2_v_q, out_valid_q;
    logic             s1_sign_d, s1_sign_q, s2_sign_q;
    logic [FXP_W-1:0] s1_mag_d, s1_mag_q, s2_norm_d, s2_norm_q;
    logic [4:0]       s2_p_d, s2_p_q;
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q, out_tag_q;
    logic [31:0]      out_fp32_d, out_fp32_q;
    logic [62:0]      ext;
    logic [23:0]      mant;
    logic             rnd;

    assign en        = out_ready | ~out_valid_q;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_fp32  = out_fp32_q;
    assign out_tag   = out_tag_q;

    // ext holds the bits below the hidden one, MSB-aligned, so rounding is width-independent
    always_comb begin
        s1_sign_d = (SIGNED != 0) & in_fxp[FXP_W-1];
        s1_mag_d = s1_sign_d ? ~in_fxp + 1'b1 : in_fxp;
        s2_p_d = '0;
        for (int i = 0; i < FXP_W; i++) if (s1_mag_q[i]) s2_p_d = 5'(i);
        s2_norm_d = s1_mag_q << (5'(FXP_W - 1) - s2_p_d);
        ext = {s2_norm_q[FXP_W-2:0], {(64-FXP_W){1'b0}}};
        rnd = ext[39] & ((|ext[38:0]) | ext[40]);
        mant = {1'b0, ext[62:40]} + {23'd0, rnd};
        out_fp32_d = s2_norm_q[FXP_W-1]
            ? {s2_sign_q, 8'(127 + int'(s2_p_q) - FRAC_W + int'(mant[23])), mant[22:0]}
            : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            s1_sign_q   <= 1'b0;
            s2_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_norm_q   <= '0;
            s2_p_q      <= '0;
            s1_tag_q    <= '0;
            s2_tag_q    <= '0;
            out_tag_q   <= '0;
            out_fp32_q  <= '0;
        end else if (en) begin
            s1_v_q      <= in_valid;
            s2_v_q      <= s1_v_q;
            out_valid_q <= s2_v_q;
            s1_sign_q   <= s1_sign_d;
            s2_sign_q   <= s1_sign_q;
            s1_mag_q    <= s1_mag_d;
            s2_norm_q   <= s2_norm_d;
            s2_p_q      <= s2_p_d;
            s1_tag_q    <= in_tag;
            s2_tag_q    <= s1_tag_q;
            out_tag_q   <= s2_tag_q;
            out_fp32_q  <= out_fp32_d;
        end
    end
endmodule

// File: tb/tb_fxp2float_pipe.sv
// tb_fxp2float_pipe: scoreboard bench for three converter configurations
// (8,4,signed), (32,0,signed) and (8,0,unsigned).
module tb_fxp2float_pipe;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] fp;
        logic [3:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;
    exp_t qa[$], qb[$], qc[$];

    logic        a_iv = 0, a_ir, a_ov, a_or = 1;
    logic [7:0]  a_fxp = 0;
    logic [3:0]  a_tag = 0, a_otag;
    logic [31:0] a_fp;

    logic        b_iv = 0, b_ir, b_ov, b_or = 1;
    logic [31:0] b_fxp = 0, b_fp;
    logic [3:0]  b_tag = 0, b_otag;

    logic        c_iv = 0, c_ir, c_ov, c_or = 1;
    logic [7:0]  c_fxp = 0;
    logic [3:0]  c_tag = 0, c_otag;
    logic [31:0] c_fp;

    fxp2float_pipe #(.FXP_W(8), .FRAC_W(4), .SIGNED(1), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_fxp(a_fxp), .in_tag(a_tag),
        .out_valid(a_ov), .out_ready(a_or), .out_fp32(a_fp), .out_tag(a_otag));

    fxp2float_pipe #(.FXP_W(32), .FRAC_W(0), .SIGNED(1), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_fxp(b_fxp), .in_tag(b_tag),
        .out_valid(b_ov), .out_ready(b_or), .out_fp32(b_fp), .out_tag(b_otag));

    fxp2float_pipe #(.FXP_W(8), .FRAC_W(0), .SIGNED(0), .TAG_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_fxp(c_fxp), .in_tag(c_tag),
        .out_valid(c_ov), .out_ready(c_or), .out_fp32(c_fp), .out_tag(c_otag));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    // Reference for the (8,4,signed) instance via double-precision conversion (exact for 8 bits)
    function automatic logic [31:0] ref_a(input logic [7:0] x);
        real r;
        logic [63:0] d;
        if (x == 8'h00) return 32'h0;
        r = $itor($signed(x)) / 16.0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // mode 0: out_ready=1 (fixed latency), 1: random out_ready, 2: out_ready=0
    task automatic send_a(input logic [7:0] x, input logic [3:0] t, input logic [31:0] e, input int mode);
        bit done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            a_or = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 0;
            a_iv = 1;
            a_fxp = x;
            a_tag = t;
            #1;
            if (a_ir) begin
                qa.push_back('{e, t, cyc, mode == 0});
                done = 1;
            end
        end
        if (!done) chk("a_send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_a(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            a_or = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 0;
            a_iv = 0;
        end
    endtask

    task automatic send_b(input logic [31:0] x, input logic [31:0] e);
        @(negedge clk);
        b_iv = 1;
        b_fxp = x;
        b_tag = b_tag + 1;
        #1;
        chk("b_in_ready", 32'(b_ir), 32'd1);
        qb.push_back('{e, b_tag, cyc, 1'b1});
    endtask

    task automatic send_c(input logic [7:0] x, input logic [31:0] e);
        @(negedge clk);
        c_iv = 1;
        c_fxp = x;
        c_tag = c_tag + 1;
        #1;
        chk("c_in_ready", 32'(c_ir), 32'd1);
        qc.push_back('{e, c_tag, cyc, 1'b1});
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (qa.size() + qb.size() + qc.size()) != 0; k++) @(negedge clk);
        chk("drain_left", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    endtask

    logic        a_hold = 0;
    logic [31:0] a_pfp = 0;
    logic [3:0]  a_ptag = 0;
    int          a_pops = 0;
    exp_t        ea, eb, ec;

    always @(negedge clk) begin
        #2;
        if (rst) a_hold = 0;
        else begin
            chk("a_in_ready", 32'(a_ir), 32'(!(a_ov && !a_or)));
            if (a_hold) begin
                chk("a_hold_fp", a_fp, a_pfp);
                chk("a_hold_tag", 32'(a_otag), 32'(a_ptag));
            end
            if (a_ov && a_or) begin
                if (qa.size() == 0) chk("a_unexpected", a_fp, 32'hxxxxxxxx);
                else begin
                    ea = qa.pop_front();
                    a_pops++;
                    chk("a_fp32", a_fp, ea.fp);
                    chk("a_tag", 32'(a_otag), 32'(ea.tag));
                    if (ea.lat) chk("a_latency", 32'(cyc - ea.acc), 32'd3);
                end
            end
            a_hold = a_ov && !a_or;
            a_pfp = a_fp;
            a_ptag = a_otag;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && b_ov) begin
            if (qb.size() == 0) chk("b_unexpected", b_fp, 32'hxxxxxxxx);
            else begin
                eb = qb.pop_front();
                chk("b_fp32", b_fp, eb.fp);
                chk("b_tag", 32'(b_otag), 32'(eb.tag));
                chk("b_latency", 32'(cyc - eb.acc), 32'd3);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && c_ov) begin
            if (qc.size() == 0) chk("c_unexpected", c_fp, 32'hxxxxxxxx);
            else begin
                ec = qc.pop_front();
                chk("c_fp32", c_fp, ec.fp);
                chk("c_tag", 32'(c_otag), 32'(ec.tag));
                chk("c_latency", 32'(cyc - ec.acc), 32'd3);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0]  da_in [6] = '{8'h10, 8'hF0, 8'h80, 8'h01, 8'h7F, 8'h00};
    logic [31:0] da_out[6] = '{32'h3F800000, 32'hBF800000, 32'hC1000000,
                               32'h3D800000, 32'h40FE0000, 32'h00000000};
    logic [31:0] db_in [8] = '{32'h01000001, 32'h01000003, 32'h7FFFFFFF, 32'h80000000,
                               32'h00000000, 32'hFFFFFFFF, 32'h00FFFFFF, 32'h01000002};
    logic [31:0] db_out[8] = '{32'h4B800000, 32'h4B800002, 32'h4F000000, 32'hCF000000,
                               32'h00000000, 32'hBF800000, 32'h4B7FFFFF, 32'h4B800001};
    logic [7:0]  dc_in [4] = '{8'hFF, 8'h80, 8'h01, 8'h00};
    logic [31:0] dc_out[4] = '{32'h437F0000, 32'h43000000, 32'h3F800000, 32'h00000000};

    initial begin
        int n0;
        logic [7:0] x;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_a_valid", 32'(a_ov), 32'd0);
        chk("rst_a_fp32", a_fp, 32'd0);
        chk("rst_a_tag", 32'(a_otag), 32'd0);
        chk("rst_b_valid", 32'(b_ov), 32'd0);
        chk("rst_c_fp32", c_fp, 32'd0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 6; i++) send_a(da_in[i], 4'(i), da_out[i], 0);
        idle_a(1, 0);
        for (int i = 0; i < 8; i++) send_b(db_in[i], db_out[i]);
        @(negedge clk);
        b_iv = 0;
        for (int i = 0; i < 4; i++) send_c(dc_in[i], dc_out[i]);
        @(negedge clk);
        c_iv = 0;
        drain();

        n0 = a_pops;
        for (int i = 0; i < 256; i++) send_a(8'(i), 4'(i), ref_a(8'(i)), 0);
        idle_a(1, 0);
        drain();
        chk("a_exh_count", 32'(a_pops - n0), 32'd256);

        for (int i = 0; i < 80; i++) begin
            x = 8'($urandom);
            send_a(x, 4'(i), ref_a(x), 1);
            if ($urandom_range(0, 3) == 0) idle_a($urandom_range(1, 3), 1);
        end
        idle_a(1, 0);
        drain();

        send_a(8'h10, 4'h1, 32'h3F800000, 2);
        send_a(8'h20, 4'h2, 32'h40000000, 2);
        idle_a(3, 2);
        #2;
        chk("a_valid_before_rst", 32'(a_ov), 32'd1);
        #1;
        rst = 1;
        #1;
        chk("a_rst_async_valid", 32'(a_ov), 32'd0);
        chk("a_rst_async_fp32", a_fp, 32'd0);
        chk("a_rst_async_tag", 32'(a_otag), 32'd0);
        qa.delete();
        @(negedge clk);
        #3;
        rst = 0;
        idle_a(8, 0);
        send_a(8'h30, 4'h3, 32'h40400000, 0);
        idle_a(1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fxp2float_pipe.md
Name: fxp2float_pipe

Overview:
Streaming, pipelined converter from parametrised signed/unsigned fixed-point (Qm.FRAC_W) to IEEE-754 binary32. Generalises the 8-bit combinational signed converter to any input width 2..32 and any fraction width. Adds round-to-nearest-even, a valid/ready handshake with backpressure, and a passthrough tag. Sits between the fixed-point encoder/decoder datapath and float-domain consumers (result capture, error metrics).

Parameters:
FXP_W, 8, input word width in bits; legal 2..32
FRAC_W, 4, fractional bits; value = fxp / 2^FRAC_W; legal 0..FXP_W-1
SIGNED, 1, 1 = two's-complement input, 0 = unsigned input
TAG_W, 4, sideband tag width carried alongside data; legal >=1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  converter accepts input this cycle
in_fxp  in  FXP_W  fixed-point input
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_fp32  out  32  binary32 result
out_tag  out  TAG_W  tag matching out_fp32

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, out_valid=0, out_fp32=0, out_tag=0. Reset mid-stream discards all in-flight words; no partial output after release.
- Pipeline: 3 register stages, global enable en = out_ready | ~out_valid; in_ready = en (combinational). Handshake: input accepted on in_valid & in_ready; output consumed on out_valid & out_ready.
- Latency: exactly 3 cycles accepted-to-out_valid with no stalls; throughput 1 word/cycle with out_ready held high.
- Stall: en=0 freezes every stage (data, tag, valid); out_fp32/out_tag stable while out_valid & ~out_ready. Bubbles are not collapsed.
- S1: sign = SIGNED ? in_fxp[FXP_W-1] : 0; mag = |in_fxp| in FXP_W unsigned bits (most-negative input handled exactly, e.g. 0x80 -> mag 0x80).
- S2: leading-one position p (0..FXP_W-1) of mag; normalise mag left so bit p becomes the hidden bit; zero flag if mag=0.
- S3: exponent = 127 + p - FRAC_W (always normal for legal params). Mantissa = 23 bits below hidden bit. If p > 23: round to nearest, ties to even, using guard bit and sticky OR of remaining bits; mantissa carry-out sets mantissa 0 and exponent+1. If p <= 23: exact, zero-filled.
- Zero input -> 0x00000000 (+0.0, never -0.0). No NaN/Inf/denormal outputs possible.
- Tag delayed identically to data; out_tag always belongs to out_fp32.
- Simultaneous accept and consume in same cycle with full pipeline: legal, no loss, no duplication.

Test Plan:
- Defaults (8,4,1): in_fxp 0x10, 0xF0, 0x80, 0x01, 0x7F, 0x00 back-to-back, out_ready=1 -> 0x3F800000, 0xBF800000, 0xC1000000, 0x3D800000, 0x40FE0000, 0x00000000 in order, first out_valid exactly 3 cycles after first accept.
- Exhaustive defaults: all 256 inputs with tags 0..15 cycling -> every out_fp32 matches software model, tags in order, count = 256.
- Backpressure: random out_ready (50%), random in_valid -> no drop/duplicate, out_fp32/out_tag stable while out_valid & ~out_ready, in_ready low only when out_valid & ~out_ready.
- Rounding (32,0,1): 0x01000001 -> 0x4B800000; 0x01000003 -> 0x4B800002; 0x7FFFFFFF -> 0x4F000000 (carry into exponent); 0x80000000 -> 0xCF000000.
- Unsigned (8,0,0): 0xFF -> 0x437F0000; 0x80 -> 0x43000000; 0x01 -> 0x3F800000.
- Reset mid-stream: 2 words in flight, assert rst 1 cycle -> out_valid 0 immediately (async), out_fp32=0, no stale word after release; next accepted word emerges 3 cycles later.
